// File: rtl/debug_exec_ctrl.sv
// UART-driven debug sequencer: loads imem byte-wise, runs/steps/resets the pipeline, reports a status byte.
// imem writes land one cycle after each rx byte; status waits in REPORT until tx_busy is low.
module debug_exec_ctrl #(
    parameter int          IMEM_ADDR_W  = 8,
    parameter logic [31:0] MAX_CYCLES   = 32'd1000000,
    parameter logic [7:0]  TIMEOUT_CODE = 8'hEE,
    parameter logic [7:0]  ACK_CODE     = 8'h4B
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic [7:0]             tx_data,
    output logic                   tx_start,
    input  logic                   tx_busy,
    output logic                   imem_we,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    output logic [7:0]             imem_wdata,
    output logic                   mips_clk_en,
    output logic                   mips_rst,
    input  logic                   mips_halted,
    input  logic [31:0]            mips_pc,
    output logic [3:0]             state_o
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_LOAD_LEN  = 4'd1,
        S_LOAD_DATA = 4'd2,
        S_RUN       = 4'd3,
        S_STEP      = 4'd4,
        S_PRST      = 4'd5,
        S_REPORT    = 4'd6,
        S_WAIT_TX   = 4'd7
    } state_t;

    localparam logic [31:0] LAST_CYC = MAX_CYCLES - 32'd1;

    state_t                 state_q, state_d;
    logic [7:0]             tx_data_q, tx_data_d;
    logic                   pc_pend_q, pc_pend_d;
    logic                   wait_first_q, wait_first_d;
    logic                   we_q, we_d;
    logic [7:0]             wdata_q, wdata_d;
    logic [IMEM_ADDR_W-1:0] addr_q, addr_d;
    logic [9:0]             cnt_q, cnt_d;
    logic [9:0]             total_q, total_d;
    logic [31:0]            cyc_q, cyc_d;

    logic unused_pc_hi;
    assign unused_pc_hi = ^mips_pc[31:8];

    always_comb begin
        state_d      = state_q;
        tx_data_d    = tx_data_q;
        pc_pend_d    = pc_pend_q;
        wait_first_d = wait_first_q;
        we_d         = 1'b0;
        wdata_d      = wdata_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        total_d      = total_q;
        cyc_d        = cyc_q;
        tx_start     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        8'h4C: state_d = S_LOAD_LEN;
                        8'h52: begin
                            if (mips_halted) begin
                                state_d   = S_REPORT;
                                tx_data_d = mips_pc[7:0];
                            end else begin
                                state_d = S_RUN;
                                cyc_d   = 32'd0;
                            end
                        end
                        8'h53:   state_d = S_STEP;
                        8'h58:   state_d = S_PRST;
                        default: ;
                    endcase
                end
            end
            S_LOAD_LEN: begin
                if (rx_valid) begin
                    if (rx_data == 8'd0) begin
                        state_d   = S_REPORT;
                        tx_data_d = ACK_CODE;
                    end else begin
                        cnt_d   = 10'd0;
                        addr_d  = '0;
                        total_d = {rx_data, 2'b00};
                        state_d = S_LOAD_DATA;
                    end
                end
            end
            S_LOAD_DATA: begin
                // cnt_q counts captured bytes; the write of the last one ends the load
                if (we_q) addr_d = addr_q + 1'b1;
                if (we_q && cnt_q == total_q) begin
                    state_d   = S_REPORT;
                    tx_data_d = ACK_CODE;
                end else if (rx_valid && cnt_q != total_q) begin
                    we_d    = 1'b1;
                    wdata_d = rx_data;
                    cnt_d   = cnt_q + 10'd1;
                end
            end
            S_RUN: begin
                cyc_d = cyc_q + 32'd1;
                if (mips_halted || (rx_valid && rx_data == 8'h48)) begin
                    state_d   = S_REPORT;
                    tx_data_d = mips_pc[7:0];
                end else if (cyc_q == LAST_CYC) begin
                    state_d   = S_REPORT;
                    tx_data_d = TIMEOUT_CODE;
                end
            end
            S_STEP: begin
                state_d   = S_REPORT;
                pc_pend_d = 1'b1;
            end
            S_PRST: begin
                state_d   = S_REPORT;
                tx_data_d = ACK_CODE;
            end
            S_REPORT: begin
                // after a step the PC is captured one cycle late, before transmitting
                if (pc_pend_q) begin
                    tx_data_d = mips_pc[7:0];
                    pc_pend_d = 1'b0;
                end else if (!tx_busy) begin
                    tx_start     = 1'b1;
                    wait_first_d = 1'b1;
                    state_d      = S_WAIT_TX;
                end
            end
            S_WAIT_TX: begin
                if (wait_first_q)  wait_first_d = 1'b0;
                else if (!tx_busy) state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            tx_data_q    <= 8'd0;
            pc_pend_q    <= 1'b0;
            wait_first_q <= 1'b0;
            we_q         <= 1'b0;
            wdata_q      <= 8'd0;
            addr_q       <= '0;
            cnt_q        <= 10'd0;
            total_q      <= 10'd0;
            cyc_q        <= 32'd0;
        end else begin
            state_q      <= state_d;
            tx_data_q    <= tx_data_d;
            pc_pend_q    <= pc_pend_d;
            wait_first_q <= wait_first_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            total_q      <= total_d;
            cyc_q        <= cyc_d;
        end
    end

    assign tx_data     = tx_data_q;
    assign imem_we     = we_q;
    assign imem_addr   = addr_q;
    assign imem_wdata  = wdata_q;
    assign mips_clk_en = (state_q == S_RUN) || (state_q == S_STEP) || (state_q == S_PRST);
    assign mips_rst    = (state_q == S_PRST);
    assign state_o     = state_q;

endmodule

// File: tb/tb_debug_exec_ctrl.sv
// Randomised bench for debug_exec_ctrl: stimulus tasks push expected imem writes and status reports,
// a monitor pops them whenever the DUT writes or transmits.
module tb_debug_exec_ctrl;
    localparam int AW = 3;

    logic          clk, rst;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic          tx_busy;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [7:0]    imem_wdata;
    logic          mips_clk_en, mips_rst, mips_halted;
    logic [31:0]   mips_pc;
    logic [3:0]    state_o;

    debug_exec_ctrl #(
        .IMEM_ADDR_W (AW),
        .MAX_CYCLES  (32'd16),
        .TIMEOUT_CODE(8'hEE),
        .ACK_CODE    (8'h4B)
    ) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .mips_clk_en(mips_clk_en), .mips_rst(mips_rst), .mips_halted(mips_halted),
        .mips_pc(mips_pc), .state_o(state_o)
    );

    typedef struct { logic [7:0] d; int en; int rs; } tx_exp_t;
    typedef struct { logic [AW-1:0] a; logic [7:0] d; } wr_exp_t;

    tx_exp_t    txq[$];
    wr_exp_t    wrq[$];
    logic [7:0] fixed_q[$];
    int         n_chk = 0;
    int         n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: counts enable/reset cycles between reports and checks every write and transmit
    initial begin
        int en_cnt, rs_cnt;
        wr_exp_t w;
        tx_exp_t e;
        en_cnt = 0;
        rs_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                en_cnt = 0;
                rs_cnt = 0;
            end else begin
                if (mips_clk_en) en_cnt++;
                if (mips_rst) rs_cnt++;
                if (imem_we) begin
                    if (wrq.size() == 0) begin
                        check("unexpected_imem_write", 32'(imem_addr), 32'hFFFF_FFFF);
                    end else begin
                        w = wrq.pop_front();
                        check("imem_addr", 32'(imem_addr), 32'(w.a));
                        check("imem_wdata", 32'(imem_wdata), 32'(w.d));
                    end
                end
                if (tx_start) begin
                    if (txq.size() == 0) begin
                        check("unexpected_tx_start", 32'(tx_data), 32'hFFFF_FFFF);
                    end else begin
                        e = txq.pop_front();
                        check("tx_data", 32'(tx_data), 32'(e.d));
                        check("clk_en_cycles", en_cnt, e.en);
                        check("mips_rst_cycles", rs_cnt, e.rs);
                        check("writes_before_report", wrq.size(), 0);
                    end
                    en_cnt = 0;
                    rs_cnt = 0;
                end
            end
        end
    end

    // UART TX model: busy rises the cycle after tx_start for a random length
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start && !rst) begin
                @(posedge clk);
                #1 tx_busy = 1'b1;
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1 tx_busy = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic push_tx(input logic [7:0] d, input int en, input int rs);
        tx_exp_t e;
        e.d = d; e.en = en; e.rs = rs;
        txq.push_back(e);
    endtask

    // Waits for the operation to drain; optionally fires a command byte during WAIT_TX
    task automatic wait_done(input bit junk);
        bit sent = 1'b0;
        int i;
        for (i = 0; i < 400; i++) begin
            if (txq.size() == 0 && wrq.size() == 0 && state_o == 4'd0) break;
            if (junk && !sent && state_o == 4'd7) begin
                sent = 1'b1;
                send(8'h53);
            end else begin
                tick();
            end
        end
        check("op_completed_in_budget", 32'(i < 400), 32'd1);
        check("state_back_to_idle", 32'(state_o), 32'd0);
    endtask

    task automatic load_op(input int n);
        logic [7:0] d;
        wr_exp_t w;
        push_tx(8'h4B, 0, 0);
        send(8'h4C);
        send(n[7:0]);
        for (int i = 0; i < 4 * n; i++) begin
            d = (fixed_q.size() != 0) ? fixed_q.pop_front() : 8'($urandom);
            w.a = AW'(i % (1 << AW));
            w.d = d;
            wrq.push_back(w);
            repeat ($urandom_range(0, 2)) tick();
            send(d);
        end
        wait_done(1'b0);
    endtask

    // PC is changed right after the enable cycle; the report must carry the later value
    task automatic step_op(input logic [31:0] a, input logic [31:0] b);
        mips_pc = a;
        push_tx(b[7:0], 1, 0);
        send(8'h53);
        tick();
        mips_pc = b;
        wait_done(1'b0);
    endtask

    // mode: 0 halt, 1 abort, 2 timeout, 3 halted at entry, 4 halt+abort together
    task automatic run_op(input int k, input int mode, input bit junk, input logic [31:0] pc);
        int kk;
        mips_pc = pc;
        if (mode == 3) begin
            mips_halted = 1'b1;
            push_tx(pc[7:0], 0, 0);
            send(8'h52);
            mips_halted = 1'b0;
        end else begin
            kk = (mode == 2) ? 16 : k;
            push_tx((mode == 2) ? 8'hEE : pc[7:0], kk, 0);
            send(8'h52);
            for (int idx = 0; idx < kk; idx++) begin
                if (idx == kk - 1 && (mode == 0 || mode == 4)) mips_halted = 1'b1;
                if (idx == kk - 1 && (mode == 1 || mode == 4)) begin
                    rx_data = 8'h48; rx_valid = 1'b1;
                end
                if (junk && idx == 0 && kk > 1) begin
                    rx_data = 8'h53; rx_valid = 1'b1;
                end
                tick();
                mips_halted = 1'b0;
                rx_valid    = 1'b0;
            end
        end
        wait_done(1'b0);
    endtask

    task automatic prst_op(input bit junk);
        push_tx(8'h4B, 1, 1);
        send(8'h58);
        wait_done(junk);
    endtask

    initial begin
        logic [7:0] b;
        wr_exp_t w;
        rst = 1'b1; rx_data = 8'd0; rx_valid = 1'b0; mips_halted = 1'b0; mips_pc = 32'd0;
        tick(); tick();
        check("rst_state_o", 32'(state_o), 32'd0);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_imem_we", 32'(imem_we), 32'd0);
        check("rst_imem_addr", 32'(imem_addr), 32'd0);
        check("rst_clk_en", 32'(mips_clk_en), 32'd0);
        check("rst_mips_rst", 32'(mips_rst), 32'd0);
        rst = 1'b0;
        tick();

        fixed_q = {8'h85, 8'h08, 8'h00, 8'h00, 8'h21, 8'h09, 8'h00, 8'h04};
        load_op(2);
        step_op(32'h8, 32'h8);
        run_op(10, 0, 1'b0, 32'h14);
        run_op(16, 2, 1'b0, 32'h33);
        run_op(0, 3, 1'b0, 32'h5A);
        run_op(5, 1, 1'b0, 32'h77);
        prst_op(1'b1);

        // Unknown and mid-run-only bytes are ignored in IDLE
        for (int i = 0; i < 6; i++) begin
            do b = 8'($urandom); while (b == 8'h4C || b == 8'h52 || b == 8'h53 || b == 8'h58);
            send(b);
            check("idle_ignores_byte", 32'(state_o), 32'd0);
        end

        load_op(0);
        load_op(3);

        // Reset in the middle of LOAD_DATA while the third byte's write is pending
        send(8'h4C);
        send(8'h02);
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            if (i < 2) begin
                w.a = AW'(i); w.d = b;
                wrq.push_back(w);
            end
            send(b);
        end
        rst = 1'b1;
        #1;
        check("midrst_imem_we", 32'(imem_we), 32'd0);
        check("midrst_imem_addr", 32'(imem_addr), 32'd0);
        check("midrst_imem_wdata", 32'(imem_wdata), 32'd0);
        check("midrst_tx_data", 32'(tx_data), 32'd0);
        check("midrst_tx_start", 32'(tx_start), 32'd0);
        check("midrst_clk_en", 32'(mips_clk_en), 32'd0);
        check("midrst_state_o", 32'(state_o), 32'd0);
        check("midrst_writes_seen", wrq.size(), 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 6))
                0: load_op($urandom_range(1, 4));
                1: step_op($urandom, $urandom);
                2: run_op($urandom_range(1, 16), $urandom_range(0, 1), 1'($urandom_range(0, 1)), $urandom);
                3: run_op(16, 2, 1'($urandom_range(0, 1)), $urandom);
                4: run_op($urandom_range(1, 16), 4, 1'b0, $urandom);
                5: run_op(0, 3, 1'b0, $urandom);
                default: prst_op(1'($urandom_range(0, 1)));
            endcase
        end

        check("final_tx_queue_empty", txq.size(), 0);
        check("final_wr_queue_empty", wrq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/debug_exec_ctrl.md
Name: debug_exec_ctrl

Overview:
- Debug-side controller that sequences the MIPS pipeline from UART commands.
- Loads a program byte-wise into instruction memory and pulses pipeline reset.
- Gates the pipeline clock enable for RUN (until halt, abort or watchdog) and STEP (one cycle).
- Reports status bytes back through the UART TX handshake. Sits between the UART RX/TX and the pipeline top.

Parameters:
- IMEM_ADDR_W, 8: instruction memory byte-address width.
- MAX_CYCLES, 32'd1000000: RUN watchdog limit, in enabled pipeline cycles.
- TIMEOUT_CODE, 8'hEE: byte reported when the watchdog expires.
- ACK_CODE, 8'h4B: byte reported after a load or pipeline reset completes.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rx_data  in  8  received UART byte.
- rx_valid  in  1  one-cycle strobe, rx_data valid.
- tx_data  out  8  byte to transmit.
- tx_start  out  1  one-cycle transmit request.
- tx_busy  in  1  UART TX busy; rises the cycle after tx_start.
- imem_we  out  1  instruction memory byte write enable.
- imem_addr  out  IMEM_ADDR_W  instruction memory byte address.
- imem_wdata  out  8  instruction memory write byte.
- mips_clk_en  out  1  pipeline clock enable.
- mips_rst  out  1  pipeline synchronous reset pulse.
- mips_halted  in  1  pipeline has retired a HALT.
- mips_pc  in  32  current pipeline PC.
- state_o  out  4  current FSM state encoding, for debug.

Behaviour:
- Reset (async, rst=1): state IDLE. All outputs 0. Internal counters 0.
- State encodings: IDLE=0, LOAD_LEN=1, LOAD_DATA=2, RUN=3, STEP=4, PRST=5, REPORT=6, WAIT_TX=7.
- IDLE: act only on rx_valid:
  - 0x4C 'L' -> LOAD_LEN.
  - 0x52 'R' -> RUN; if mips_halted=1 at entry, go directly to REPORT with tx byte mips_pc[7:0] and never assert mips_clk_en.
  - 0x53 'S' -> STEP.
  - 0x58 'X' -> PRST.
  - Any other byte is ignored.
- LOAD_LEN: the next rx byte N is the word count.
  - N=0 -> REPORT with ACK_CODE.
  - Otherwise clear the byte counter and the address to 0, store byte total 4N, and go to LOAD_DATA.
- LOAD_DATA: each rx_valid byte is registered.
  - The next cycle drives imem_we=1 for exactly one cycle with imem_addr=current address and imem_wdata=byte (1-cycle latency).
  - The address then increments and wraps modulo 2^IMEM_ADDR_W.
  - Bytes arrive big-endian: MSB first, at the lowest address.
  - After byte 4N is written -> REPORT with ACK_CODE.
- RUN:
  - mips_clk_en=1 from the cycle after entry.
  - The cycle counter increments on each enabled cycle.
  - Exit conditions, each deasserting mips_clk_en on the next edge:
    - mips_halted=1 -> REPORT with mips_pc[7:0].
    - rx_valid with 0x48 'H' -> REPORT with mips_pc[7:0].
    - counter==MAX_CYCLES-1 -> REPORT with TIMEOUT_CODE.
  - Priority when events coincide: halted > abort > timeout.
  - Other rx bytes during RUN are dropped.
- STEP:
  - mips_clk_en=1 for exactly one cycle, regardless of mips_halted.
  - Next cycle -> REPORT, sampling mips_pc[7:0] in that cycle.
- PRST: mips_rst=1 for exactly one cycle, mips_clk_en=1 in the same cycle, then REPORT with ACK_CODE.
- REPORT:
  - Wait for tx_busy=0.
  - Then tx_start=1 for one cycle with tx_data held, and go to WAIT_TX.
- WAIT_TX:
  - Ignore tx_busy in the first cycle.
  - Then return to IDLE when tx_busy=0.
  - tx_data holds its value until the next REPORT.
- rx bytes received in REPORT, WAIT_TX, STEP or PRST are dropped.
- Reset mid-operation (any state): immediate return to the reset values. Partially loaded memory is not cleared.

Test Plan:
1. Load: send 4C 02 85 08 00 00 21 09 00 04 -> eight imem_we pulses, addresses 0..7, data in send order; then tx_start with tx_data=0x4B; state_o returns to 0.
2. Step: in IDLE with mips_pc=0x00000008, send 53 -> mips_clk_en high exactly 1 cycle; tx_data=0x08 (PC sampled the cycle after the enable).
3. Run to halt: send 52, assert mips_halted after 10 cycles with mips_pc=0x14 -> mips_clk_en high 10 cycles, drops the next edge; tx_data=0x14.
4. Watchdog: MAX_CYCLES=16, send 52, mips_halted held 0 -> exactly 16 enabled cycles, tx_data=0xEE. Then send 52 with mips_halted=1 -> no enable cycles, immediate report.
5. Abort and PRST: send 52, then 48 on cycle 5 -> enable stops, PC byte reported. Then send 58 -> one-cycle mips_rst, then 0x4B. Rx bytes sent during WAIT_TX are ignored.
6. Boundary: load with N=0 -> immediate 0x4B and no writes. IMEM_ADDR_W=3 with N=3 -> addresses wrap 7->0. rst asserted in LOAD_DATA -> all outputs 0 the same cycle.
